// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED text streamer.
// State encoding, padding byte and handshake flag levels.
package oled_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      ARM,
      SEND,
      FIN
   } state_t;

   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam logic HS_IDLE   = 1'b0;
   localparam logic HS_ACTIVE = 1'b1;

endpackage

// File: rtl/oled_text_streamer_if.sv
// Byte handshake between the text streamer and oledControl.
// The streamer is the master; oledControl answers with sendDone.
interface oled_text_streamer_if;

   logic [7:0] sendData;
   logic       sendDataValid;
   logic       sendDone;

   modport master (
      output sendData,
      output sendDataValid,
      input  sendDone
   );

   modport slave (
      input  sendData,
      input  sendDataValid,
      output sendDone
   );

endinterface

// File: rtl/oled_text_ram.sv
// Character buffer: DEPTH x 8, one sync write port, one sync read port.
// The array is deliberately left unreset so contents survive reset.
module oled_text_ram #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/oled_text_streamer.sv
// Streams a run-time length prefix of a character buffer to oledControl,
// optionally padding the rest of the frame with PAD_CHAR.
module oled_text_streamer
   import oled_pkg::*;
#(
   parameter int         DEPTH    = 64,
   parameter int         ADDR_W   = $clog2(DEPTH),
   parameter int         LEN_W    = $clog2(DEPTH) + 1,
   parameter logic [7:0] PAD_CHAR = ASCII_SPACE
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [LEN_W-1:0]  msg_len,
   input  logic              pad_en,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  char_count,
   oled_text_streamer_if.master oled
);

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] tot_q, tot_d;
   logic [7:0]       data_q, data_d;
   logic             vld_q, vld_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [7:0]       rd_data;
   logic [LEN_W-1:0] len_clamp;
   logic [LEN_W-1:0] tot_start;
   logic             start_ok;
   logic             in_xfer;

   assign len_clamp = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
   assign tot_start = pad_en ? DEPTH_L : len_clamp;
   assign start_ok  = start && !abort;
   assign in_xfer   = state_q inside {FETCH, LOAD, ARM, SEND};

   oled_text_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clock),
      .we_i    (wr_en && !busy_q),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (idx_q[ADDR_W-1:0]),
      .rdata_o (rd_data)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      tot_d   = tot_q;
      data_d  = data_q;
      vld_d   = vld_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (abort && in_xfer) begin
         state_d = IDLE;
         vld_d   = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_ok) begin
                  len_d = len_clamp;
                  tot_d = tot_start;
                  idx_d = '0;
                  cnt_d = '0;
                  if (tot_start == '0) begin
                     state_d = FIN;
                  end else begin
                     state_d = FETCH;
                     busy_d  = 1'b1;
                  end
               end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
               data_d  = (idx_q < len_q) ? rd_data : PAD_CHAR;
               state_d = ARM;
            end
            // A done level left over from the previous byte must clear first.
            ARM: begin
               if (oled.sendDone == HS_IDLE) begin
                  vld_d   = 1'b1;
                  state_d = SEND;
               end
            end
            SEND: begin
               if (oled.sendDone == HS_ACTIVE) begin
                  vld_d   = 1'b0;
                  idx_d   = idx_q + ONE_L;
                  cnt_d   = cnt_q + ONE_L;
                  state_d = (idx_q == tot_q - ONE_L) ? FIN : FETCH;
               end
            end
            FIN: begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         tot_q   <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         tot_q   <= tot_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy               = busy_q;
   assign done               = done_q;
   assign char_count         = cnt_q;
   assign oled.sendData      = data_q;
   assign oled.sendDataValid = vld_q;

endmodule

// File: tb/tb_oled_text_streamer.sv
// Bench for oled_text_streamer: random buffer contents and transfer
// settings checked against a byte-sequence model and a downstream responder.
module tb_oled_text_streamer;

   localparam int DEPTH = 64;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_en   = 1'b0;
   logic [5:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [6:0] msg_len = '0;
   logic       pad_en  = 1'b0;
   logic       start   = 1'b0;
   logic       abort   = 1'b0;
   logic       busy;
   logic       done;
   logic [6:0] char_count;

   oled_text_streamer_if dsif ();

   oled_text_streamer #(.DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .msg_len    (msg_len),
      .pad_en     (pad_en),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .char_count (char_count),
      .oled       (dsif)
   );

   always #5 clock = ~clock;

   int         n_chk = 0;
   int         n_fail = 0;
   byte unsigned mem_m [DEPTH];
   logic [7:0] rxq [$];
   int         done_cnt = 0;
   int         vld_cnt = 0;
   int         proto_err = 0;
   int         hold_len = 1;
   bit         resp_en = 1'b1;

   // oledControl stand-in: random latency, sendDone held hold_len cycles
   initial begin
      int dly;
      int hc;
      logic pv;
      logic [7:0] pd;
      dly = 0; hc = 0; pv = 1'b0; pd = '0;
      dsif.sendDone = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            dsif.sendDone = 1'b0;
            hc = 0;
            pv = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (dsif.sendDataValid) vld_cnt++;
            if (dsif.sendDataValid && !pv && dsif.sendDone) proto_err++;
            if (dsif.sendDataValid && pv && dsif.sendData !== pd) proto_err++;
            pv = dsif.sendDataValid;
            pd = dsif.sendData;
            if (dsif.sendDone) begin
               hc--;
               if (hc <= 0) dsif.sendDone = 1'b0;
            end else if (dsif.sendDataValid && resp_en) begin
               if (dly == 0) begin
                  dsif.sendDone = 1'b1;
                  rxq.push_back(dsif.sendData);
                  hc = hold_len;
                  dly = $urandom_range(0, 3);
               end else begin
                  dly--;
               end
            end
         end
      end
   end

   function automatic int exp_total(int len, bit pad);
      int l;
      l = (len > DEPTH) ? DEPTH : len;
      return pad ? DEPTH : l;
   endfunction

   function automatic logic [7:0] exp_byte(int i, int len);
      int l;
      l = (len > DEPTH) ? DEPTH : len;
      return (i < l) ? mem_m[i] : 8'h20;
   endfunction

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      wr_en = 1'b1;
      wr_addr = a[5:0];
      wr_data = d;
      step();
      wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
   endtask

   task automatic run_xfer(input int len, input bit pad, input bit wr_busy,
                           output bit to);
      rxq.delete();
      done_cnt = 0;
      vld_cnt = 0;
      msg_len = 7'(len);
      pad_en = pad;
      start = 1'b1;
      step();
      start = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         if (wr_busy && i == 2) begin
            wr_en = 1'b1;
            wr_addr = '0;
            wr_data = ~mem_m[0];
         end else begin
            wr_en = 1'b0;
         end
         step();
         if (done_cnt > 0) begin
            to = 1'b0;
            break;
         end
      end
      wr_en = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step();
      step();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
      n_chk++; if (char_count !== 7'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", char_count); end
      n_chk++; if (dsif.sendDataValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", dsif.sendDataValid); end
      n_chk++; if (dsif.sendData !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", dsif.sendData); end
      reset_n = 1'b1;
      step();
      fill_rand();
   endtask

   task automatic test_hi();
      bit to;
      wr(0, 8'h48);
      wr(1, 8'h49);
      proto_err = 0;
      run_xfer(2, 1'b0, 1'b0, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL hi_timeout got no done exp done"); end
      n_chk++; if (rxq.size() !== 2) begin n_fail++; $display("FAIL hi_nbytes got %0d exp 2", rxq.size()); end
      n_chk++; if (rxq.size() < 1 || rxq[0] !== 8'h48) begin n_fail++; $display("FAIL hi_byte0 exp 48"); end
      n_chk++; if (rxq.size() < 2 || rxq[1] !== 8'h49) begin n_fail++; $display("FAIL hi_byte1 exp 49"); end
      n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL hi_done got %0d pulses exp 1", done_cnt); end
      n_chk++; if (char_count !== 7'd2) begin n_fail++; $display("FAIL hi_count got %0d exp 2", char_count); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hi_busy got %b exp 0", busy); end
      n_chk++; if (proto_err !== 0) begin n_fail++; $display("FAIL hi_proto got %0d exp 0", proto_err); end
   endtask

   task automatic test_pad();
      bit to;
      run_xfer(2, 1'b1, 1'b0, to);
      n_chk++; if (rxq.size() !== DEPTH) begin n_fail++; $display("FAIL pad_nbytes got %0d exp %0d", rxq.size(), DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         n_chk++;
         if (i >= rxq.size() || rxq[i] !== exp_byte(i, 2)) begin
            n_fail++;
            $display("FAIL pad_byte %0d exp %h", i, exp_byte(i, 2));
         end
      end
      n_chk++; if (char_count !== 7'd64) begin n_fail++; $display("FAIL pad_count got %0d exp 64", char_count); end
      n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL pad_done got %0d exp 1", done_cnt); end
   endtask

   task automatic test_zero_and_clamp();
      bit to;
      int n;
      done_cnt = 0;
      vld_cnt = 0;
      msg_len = '0;
      pad_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_early got %b exp 0", done); end
      step();
      n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_at2 got %b exp 1", done); end
      step();
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_len got %b exp 0", done); end
      step();
      n_chk++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL zero_valid got %0d cycles exp 0", vld_cnt); end
      fill_rand();
      run_xfer(100, 1'b0, 1'b0, to);
      n = exp_total(100, 1'b0);
      n_chk++; if (rxq.size() !== n) begin n_fail++; $display("FAIL clamp_nbytes got %0d exp %0d", rxq.size(), n); end
      for (int i = 0; i < n; i++) begin
         n_chk++;
         if (i >= rxq.size() || rxq[i] !== exp_byte(i, 100)) begin
            n_fail++;
            $display("FAIL clamp_byte %0d exp %h", i, exp_byte(i, 100));
         end
      end
      n_chk++; if (char_count !== 7'(n)) begin n_fail++; $display("FAIL clamp_count got %0d exp %0d", char_count, n); end
   endtask

   task automatic test_hold5();
      bit to;
      hold_len = 5;
      proto_err = 0;
      run_xfer(6, 1'b0, 1'b0, to);
      n_chk++; if (proto_err !== 0) begin n_fail++; $display("FAIL hold_proto got %0d exp 0", proto_err); end
      n_chk++; if (rxq.size() !== 6) begin n_fail++; $display("FAIL hold_nbytes got %0d exp 6", rxq.size()); end
      for (int i = 0; i < 6; i++) begin
         n_chk++;
         if (i >= rxq.size() || rxq[i] !== exp_byte(i, 6)) begin
            n_fail++;
            $display("FAIL hold_byte %0d exp %h", i, exp_byte(i, 6));
         end
      end
      hold_len = 1;
   endtask

   task automatic test_abort();
      bit to;
      int k;
      rxq.delete();
      done_cnt = 0;
      msg_len = 7'd10;
      pad_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (rxq.size() < 3 && k < 2000) begin
         step();
         k++;
      end
      n_chk++; if (k >= 2000) begin n_fail++; $display("FAIL abort_wait got %0d bytes exp 3", rxq.size()); end
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_chk++; if (dsif.sendDataValid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b exp 0", dsif.sendDataValid); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
      n_chk++; if (char_count !== 7'd3) begin n_fail++; $display("FAIL abort_count got %0d exp 3", char_count); end
      for (int i = 0; i < 6; i++) step();
      n_chk++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
      n_chk++; if (rxq.size() !== 3) begin n_fail++; $display("FAIL abort_extra got %0d exp 3", rxq.size()); end
      run_xfer(10, 1'b0, 1'b0, to);
      n_chk++; if (rxq.size() !== 10) begin n_fail++; $display("FAIL resend_nbytes got %0d exp 10", rxq.size()); end
      for (int i = 0; i < 10; i++) begin
         n_chk++;
         if (i >= rxq.size() || rxq[i] !== exp_byte(i, 10)) begin
            n_fail++;
            $display("FAIL resend_byte %0d exp %h", i, exp_byte(i, 10));
         end
      end
   endtask

   task automatic test_reset_mid();
      int k;
      wr(0, 8'hA5);
      resp_en = 1'b0;
      msg_len = 7'd5;
      pad_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (!dsif.sendDataValid && k < 20) begin
         step();
         k++;
      end
      n_chk++; if (k >= 20) begin n_fail++; $display("FAIL rmid_wait got valid %b exp 1", dsif.sendDataValid); end
      reset_n = 1'b0;
      #1;
      n_chk++; if (dsif.sendDataValid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", dsif.sendDataValid); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", busy); end
      n_chk++; if (dsif.sendData !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h exp 00", dsif.sendData); end
      step();
      reset_n = 1'b1;
      resp_en = 1'b1;
      step();
   endtask

   task automatic test_busy_write();
      bit to;
      run_xfer(3, 1'b0, 1'b1, to);
      run_xfer(1, 1'b0, 1'b0, to);
      n_chk++;
      if (rxq.size() !== 1 || rxq[0] !== mem_m[0]) begin
         n_fail++;
         $display("FAIL busy_write got %0d bytes, byte0 exp %h", rxq.size(), mem_m[0]);
      end
   endtask

   task automatic test_random();
      bit to;
      int len;
      bit pad;
      int n;
      for (int it = 0; it < 5; it++) begin
         for (int j = 0; j < 8; j++) wr($urandom_range(0, DEPTH - 1), 8'($urandom));
         len = $urandom_range(0, 80);
         pad = 1'($urandom);
         hold_len = $urandom_range(1, 5);
         proto_err = 0;
         run_xfer(len, pad, 1'b0, to);
         n = exp_total(len, pad);
         n_chk++; if (to) begin n_fail++; $display("FAIL rnd%0d_timeout len %0d pad %0d", it, len, pad); end
         n_chk++; if (rxq.size() !== n) begin n_fail++; $display("FAIL rnd%0d_nbytes got %0d exp %0d", it, rxq.size(), n); end
         for (int i = 0; i < n; i++) begin
            n_chk++;
            if (i >= rxq.size() || rxq[i] !== exp_byte(i, len)) begin
               n_fail++;
               $display("FAIL rnd%0d_byte %0d exp %h", it, i, exp_byte(i, len));
            end
         end
         n_chk++; if (char_count !== 7'(n)) begin n_fail++; $display("FAIL rnd%0d_count got %0d exp %0d", it, char_count, n); end
         n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rnd%0d_done got %0d exp 1", it, done_cnt); end
         n_chk++; if (proto_err !== 0) begin n_fail++; $display("FAIL rnd%0d_proto got %0d exp 0", it, proto_err); end
      end
      hold_len = 1;
   endtask

   initial begin
      test_reset();
      test_hi();
      test_pad();
      test_zero_and_clamp();
      test_hold5();
      test_abort();
      test_reset_mid();
      test_busy_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
